// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame receiver: FSM state encoding and
// default frame/buffer sizing.
package serial_frame_pkg;

    localparam int DATA_BITS_DEF  = 8;
    localparam int FIFO_DEPTH_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Purpose: small synchronous word buffer; head word shown on rdata (zero when empty).
// Latency: a pushed word is visible on rdata the cycle after the push into an empty buffer.
// Backpressure: push while full is accepted only alongside a pop; pop while empty is ignored.
module sync_fifo
    import serial_frame_pkg::*;
#(
    parameter int WIDTH = DATA_BITS_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             c,
    input  logic             r,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge c) begin
        if (r) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge c) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Storage is not reset, so mask the head while empty to keep q_data at zero.
    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/serial_frame_rx.sv
// Purpose: strobed serial receiver (start, DATA_BITS LSB-first, stop) into an output buffer.
// Latency: q_valid rises the cycle after the stop-bit strobe when the buffer was empty.
// Backpressure: q_valid/q_ready; a good frame arriving at a full buffer without a pop is dropped with ovf.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                 c,
    input  logic                 r,
    input  logic                 d,
    input  logic                 en,
    output logic [DATA_BITS-1:0] q_data,
    output logic                 q_valid,
    input  logic                 q_ready,
    output logic                 ferr,
    output logic                 ovf,
    output logic                 busy
);

    localparam int CW = $clog2(DATA_BITS);

    state_t               state;
    state_t               state_nxt;
    logic [CW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_q;
    logic                 frame_done;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;

    always_ff @(posedge c) begin
        if (r) state <= IDLE;
        else   state <= state_nxt;
    end

    // The stop-bit strobe always ends the frame; its value only selects push vs. ferr.
    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        case (state)
            IDLE: if (en && !d) state_nxt = DATA;
            DATA: if (en && bit_cnt == CW'(DATA_BITS-1)) state_nxt = STOP;
            STOP: if (en) begin
                state_nxt  = IDLE;
                frame_done = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge c) begin
        if (r) begin
            bit_cnt <= '0;
            shift_q <= '0;
            ferr    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            ferr <= frame_done & ~d;
            ovf  <= frame_done & d & fifo_full & ~pop;
            if (en) begin
                case (state)
                    IDLE: bit_cnt <= '0;
                    DATA: begin
                        shift_q <= {d, shift_q[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign q_valid = ~fifo_empty;
    assign pop     = q_valid & q_ready;
    assign push    = frame_done & d & (~fifo_full | pop);
    assign busy    = (state != IDLE);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .c     (c),
        .r     (r),
        .push  (push),
        .wdata (shift_q),
        .pop   (pop),
        .rdata (q_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (range 5..16).
REQ-002 Parameter FIFO_DEPTH, default 2, output buffer depth in words (power of two, >=2).
REQ-003 c  in  1  clock; all state changes on posedge c.
REQ-004 r  in  1  reset; synchronous, active-high.
REQ-005 d  in  1  serial line bit, driven by the upstream D-FF output q.
REQ-006 en  in  1  bit strobe; d is sampled only in cycles where en=1.
REQ-007 q_data  out  DATA_BITS  received word, head of output buffer.
REQ-008 q_valid  out  1  q_data holds a valid word.
REQ-009 q_ready  in  1  consumer accepts q_data this cycle.
REQ-010 ferr  out  1  one-cycle pulse: frame discarded, stop bit was 0.
REQ-011 ovf  out  1  one-cycle pulse: good frame discarded, buffer full.
REQ-012 busy  out  1  high while a frame is in progress (state != IDLE).

Function
REQ-013 The block SHALL have three states: IDLE, DATA, STOP; it SHALL hold all state in cycles with en=0.
REQ-014 IDLE: en=1 and d=0 (start bit) SHALL go to DATA with bit count 0; en=1 and d=1 SHALL stay in IDLE.
REQ-015 DATA: each en=1 SHALL shift d into the word LSB-first and increment the count; the DATA_BITS-th bit SHALL go to STOP.
REQ-016 STOP: en=1 SHALL always return to IDLE; d=1 SHALL push the word; d=0 SHALL discard it and pulse ferr for exactly the following cycle.
REQ-017 A push SHALL be accepted if the buffer is not full or a pop occurs in the same cycle; otherwise the word SHALL be dropped and ovf SHALL pulse for exactly the following cycle.
REQ-018 A pop SHALL occur when q_valid=1 and q_ready=1; pop and push in one cycle SHALL both take effect.
REQ-019 Latency: q_valid SHALL rise the cycle after the stop-bit strobe when the buffer was empty.
REQ-020 q_data SHALL remain stable while q_valid=1 and q_ready=0; words SHALL leave in arrival order.
REQ-021 q_ready asserted with q_valid=0 SHALL have no effect; the pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 A stop bit of 0 SHALL NOT be treated as a start bit; the next en=1 in IDLE decides.

Reset
REQ-023 With r=1 at a posedge, the block SHALL enter IDLE with count 0, shift register 0, buffer empty, q_valid=0, q_data=0, ferr=0, ovf=0, busy=0.
REQ-024 Reset mid-frame SHALL discard the partial word and all buffered words without pulsing ferr or ovf.
REQ-025 Reset SHALL take priority over en, q_ready and all other inputs in the same cycle.

Structure
REQ-026 Package serial_frame_pkg SHALL hold the state encoding (IDLE, DATA, STOP) and the DATA_BITS and FIFO_DEPTH defaults.
REQ-027 The output buffer SHALL be a separate sub-module sync_fifo (c, r, push, wdata, pop, rdata, full, empty), instantiated once.
REQ-028 The frame FSM, bit counter and shift register SHALL live in serial_frame_rx.

Verification
REQ-029 en=1 every cycle, d=0,1,0,1,0,0,1,0,1,1 -> q_valid=1 one cycle after the stop bit, q_data=0xA5, ferr=0, ovf=0.
REQ-030 Frame 0x3C with stop bit 0 -> ferr pulses one cycle, q_valid stays 0, busy=0 afterwards.
REQ-031 q_ready=0, frames 0x01, 0x02, 0x03 -> ovf pulses once after the third; then q_ready=1 yields 0x01 then 0x02, then q_valid=0.
REQ-032 Buffer full (0x11, 0x22), q_ready=1 during the stop strobe of 0x33 -> no ovf; output order 0x11, 0x22, 0x33.
REQ-033 en every 4th cycle with random d on the other cycles, frame 0xA5 -> q_data=0xA5; only strobed cycles matter.
REQ-034 r=1 for one cycle after 4 data bits -> busy=0, q_valid=0 next cycle; a following frame 0x5A is received as 0x5A.
